regfile_dual_wr: RTL and testbench
==================================

Name: regfile_dual_wr

Overview:
Parametrised register file for the pipelined CPU and its successors.
- Two combinational read ports and two write ports (EX-late and MEM/WB writeback) with byte enables.
- Optional same-cycle write-to-read bypass.
- A per-register pending scoreboard that the hazard unit uses to stall.
- Register 0 is hard-wired to zero, is never written and is never pending.

Parameters:
DATA_W, 32, register width in bits; must be a multiple of 8.
ADDR_W, 5, address width; depth = 2**ADDR_W entries, entry 0 read-only zero.
BYPASS, 1, 1 = a read sees data being written in the same cycle; 0 = a read sees stored contents only.

Ports:
clk  in  1  clock; all state updates on the rising edge.
clrn  in  1  asynchronous, active-low reset.
rna  in  ADDR_W  read address, port A.
rnb  in  ADDR_W  read address, port B.
qa  out  DATA_W  read data, port A (combinational).
qb  out  DATA_W  read data, port B (combinational).
busy_a  out  1  the register at rna has a write outstanding.
busy_b  out  1  the register at rnb has a write outstanding.
we0  in  1  write enable, port 0.
wn0  in  ADDR_W  write address, port 0.
d0  in  DATA_W  write data, port 0.
be0  in  DATA_W/8  byte enables, port 0.
we1  in  1  write enable, port 1 (higher priority).
wn1  in  ADDR_W  write address, port 1.
d1  in  DATA_W  write data, port 1.
be1  in  DATA_W/8  byte enables, port 1.
pend_set  in  1  issue: mark pend_wn pending.
pend_wn  in  ADDR_W  register to mark.

Behaviour:
Reset
- clrn low → all entries = 0 and all pending bits = 0, immediately (asynchronous).
- While clrn is low, qa, qb, busy_a and busy_b are 0 and bypass is suppressed.
- Release is synchronous-safe: the first rising edge after clrn goes high performs normal updates.

Writes
- Port p is effective when we_p = 1 and wn_p != 0. Writes to address 0 are ignored.
- Byte lane k of entry wn_p takes d_p[8k+7:8k] if be_p[k] = 1; otherwise the lane holds its value.
- Both ports hitting the same entry: lanes are merged per byte. Port 1 wins lanes where be1[k] = 1; port 0 supplies lanes where only be0[k] = 1.
- Effective writes with be = 0 change no data but still count as a writeback (clear pending).

Reads
- rn = 0 → q = 0 regardless of bypass.
- BYPASS = 0 → q = stored entry.
- BYPASS = 1 → per lane: port 1 data if port 1 is effective to rn with that lane enabled; else port 0 data under the same rule; else the stored lane.
- Zero-cycle read latency. A registered write is visible through storage from the cycle after the edge.

Scoreboard
- One pending bit per entry 1..2**ADDR_W-1.
- At the rising edge: any effective write to entry n clears pend[n]. pend_set with pend_wn = n != 0 sets pend[n].
- Simultaneous set and clear on the same n: set wins, because a newer producer has issued.
- pend_set with pend_wn = 0 is ignored.
- Setting an already-pending entry leaves it pending; there is no counting, and a single writeback clears it.
- busy_x = pend[rn_x] for rn_x != 0. Under BYPASS = 1, busy_x is forced 0 when an effective write to rn_x occurs in the same cycle, even with be = 0, and that write's data is forwarded on q_x.
- busy_x is always 0 for rn_x = 0.

Timing
- No combinational path from pend_set or pend_wn to busy outputs.
- Paths from we, wn, d and be to q and busy exist only under BYPASS = 1.

Test Plan:
- Reset:
  - Drive clrn = 0 mid-operation after writes to r5 = 0x12345678 and pend_set r7.
  - Read r5 and r7 → qa = 0, busy = 0; both remain 0 after release.
- Byte write:
  - we0 = 1, wn0 = 3, d0 = 0xAABBCCDD, be0 = 1111; next cycle be0 = 0010, d0 = 0x00001100.
  - Read r3 → 0xAABB11DD.
- Collision merge:
  - Same cycle: port 0 writes r4 = 0x11111111 with be0 = 1111; port 1 writes r4 = 0x22222222 with be1 = 0101.
  - Next cycle r4 = 0x11221122. With BYPASS = 1, rna = 4 shows 0x11221122 in the write cycle.
- Zero register:
  - Write r0 = 0xFFFFFFFF on both ports and pend_set r0.
  - qa = qb = 0, busy_a = 0.
- Scoreboard:
  - pend_set r9 → busy_a = 1 for rna = 9 from the next cycle.
  - Port 1 write r9 with be1 = 0000 → busy_a = 0 in the same cycle (BYPASS = 1), or from the next cycle (BYPASS = 0); data unchanged.
- Set/clear race:
  - r6 pending; in the same cycle a port 0 write to r6 and pend_set r6.
  - Next cycle busy = 1, and r6 holds the new data.

Source files
------------

// File: rtl/regfile_dual_wr.sv
// rtl/regfile_dual_wr.sv - dual-write register file with byte enables, optional bypass and pending scoreboard
module regfile_dual_wr #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5,
  parameter int BYPASS = 1
) (
  input  logic                clk,
  input  logic                clrn,
  input  logic [ADDR_W-1:0]   rna,
  input  logic [ADDR_W-1:0]   rnb,
  output logic [DATA_W-1:0]   qa,
  output logic [DATA_W-1:0]   qb,
  output logic                busy_a,
  output logic                busy_b,
  input  logic                we0,
  input  logic [ADDR_W-1:0]   wn0,
  input  logic [DATA_W-1:0]   d0,
  input  logic [DATA_W/8-1:0] be0,
  input  logic                we1,
  input  logic [ADDR_W-1:0]   wn1,
  input  logic [DATA_W-1:0]   d1,
  input  logic [DATA_W/8-1:0] be1,
  input  logic                pend_set,
  input  logic [ADDR_W-1:0]   pend_wn
);

  localparam int NB    = DATA_W / 8;
  localparam int DEPTH = 1 << ADDR_W;

  logic [DATA_W-1:0] regs_q [DEPTH];
  logic [DATA_W-1:0] regs_d [DEPTH];
  logic [DEPTH-1:0]  pend_q;
  logic [DEPTH-1:0]  pend_d;

  logic eff0, eff1;
  assign eff0 = we0 && (wn0 != '0);
  assign eff1 = we1 && (wn1 != '0);

  // Per-lane merge shared by the storage update and the read bypass: port 1 beats port 0.
  function automatic logic [DATA_W-1:0] merge_lanes(
    input logic [DATA_W-1:0] stored,
    input logic              hit0,
    input logic [DATA_W-1:0] wd0,
    input logic [NB-1:0]     wbe0,
    input logic              hit1,
    input logic [DATA_W-1:0] wd1,
    input logic [NB-1:0]     wbe1
  );
    logic [DATA_W-1:0] r;
    r = stored;
    for (int k = 0; k < NB; k++) begin
      if (hit1 && wbe1[k])
        r[8*k +: 8] = wd1[8*k +: 8];
      else if (hit0 && wbe0[k])
        r[8*k +: 8] = wd0[8*k +: 8];
    end
    return r;
  endfunction

  always_comb begin
    for (int n = 0; n < DEPTH; n++) begin
      regs_d[n] = regs_q[n];
      pend_d[n] = pend_q[n];
    end
    for (int n = 1; n < DEPTH; n++) begin
      regs_d[n] = merge_lanes(regs_q[n],
                              eff0 && (wn0 == ADDR_W'(n)), d0, be0,
                              eff1 && (wn1 == ADDR_W'(n)), d1, be1);
      // A newer producer issuing in the same cycle as the old writeback keeps the entry pending.
      if (pend_set && (pend_wn == ADDR_W'(n)))
        pend_d[n] = 1'b1;
      else if ((eff0 && (wn0 == ADDR_W'(n))) || (eff1 && (wn1 == ADDR_W'(n))))
        pend_d[n] = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      for (int n = 0; n < DEPTH; n++) regs_q[n] <= '0;
      pend_q <= '0;
    end else begin
      for (int n = 0; n < DEPTH; n++) regs_q[n] <= regs_d[n];
      pend_q <= pend_d;
    end
  end

  logic hit0_a, hit1_a, hit0_b, hit1_b;
  logic [DATA_W-1:0] rd_a, rd_b;

  always_comb begin
    hit0_a = (BYPASS != 0) && eff0 && (wn0 == rna);
    hit1_a = (BYPASS != 0) && eff1 && (wn1 == rna);
    hit0_b = (BYPASS != 0) && eff0 && (wn0 == rnb);
    hit1_b = (BYPASS != 0) && eff1 && (wn1 == rnb);
    rd_a   = merge_lanes(regs_q[rna], hit0_a, d0, be0, hit1_a, d1, be1);
    rd_b   = merge_lanes(regs_q[rnb], hit0_b, d0, be0, hit1_b, d1, be1);

    qa     = '0;
    qb     = '0;
    busy_a = 1'b0;
    busy_b = 1'b0;
    if (clrn && (rna != '0)) begin
      qa     = rd_a;
      busy_a = pend_q[rna] && !(hit0_a || hit1_a);
    end
    if (clrn && (rnb != '0)) begin
      qb     = rd_b;
      busy_b = pend_q[rnb] && !(hit0_b || hit1_b);
    end
  end

endmodule

// File: tb/tb_regfile_dual_wr.sv
// tb/tb_regfile_dual_wr.sv - directed self-checking bench for regfile_dual_wr
module tb_regfile_dual_wr;

  logic        clk = 1'b0;
  logic        clrn;
  logic [4:0]  rna, rnb, wn0, wn1, pend_wn;
  logic [31:0] qa, qb, d0, d1;
  logic        busy_a, busy_b, we0, we1, pend_set;
  logic [3:0]  be0, be1;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  regfile_dual_wr #(.DATA_W(32), .ADDR_W(5), .BYPASS(1)) dut (
    .clk(clk), .clrn(clrn),
    .rna(rna), .rnb(rnb), .qa(qa), .qb(qb), .busy_a(busy_a), .busy_b(busy_b),
    .we0(we0), .wn0(wn0), .d0(d0), .be0(be0),
    .we1(we1), .wn1(wn1), .d1(d1), .be1(be1),
    .pend_set(pend_set), .pend_wn(pend_wn)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    we0 = 0; we1 = 0; pend_set = 0;
    wn0 = 0; wn1 = 0; pend_wn = 0;
    d0 = 0; d1 = 0; be0 = 0; be1 = 0;
  endtask

  initial begin
    clrn = 0; rna = 0; rnb = 0;
    idle();
    #2;
    rna = 5; rnb = 7;
    #1;
    check("reset_qa", qa, 32'h0);
    check("reset_busy_b", {31'b0, busy_b}, 32'h0);
    step();
    clrn = 1;
    step();

    // write r5, mark r7 pending, then reset mid-operation
    we0 = 1; wn0 = 5; d0 = 32'h12345678; be0 = 4'hF;
    pend_set = 1; pend_wn = 7;
    step();
    idle();
    #1;
    check("pre_rst_r5", qa, 32'h12345678);
    check("pre_rst_busy7", {31'b0, busy_b}, 32'h1);
    clrn = 0;
    #1;
    check("rst_r5", qa, 32'h0);
    check("rst_busy7", {31'b0, busy_b}, 32'h0);
    step();
    clrn = 1;
    step();
    check("post_rst_r5", qa, 32'h0);
    check("post_rst_busy7", {31'b0, busy_b}, 32'h0);

    // byte write
    rna = 3;
    we0 = 1; wn0 = 3; d0 = 32'hAABBCCDD; be0 = 4'hF;
    step();
    be0 = 4'b0010; d0 = 32'h00001100;
    #1;
    check("byte_bypass", qa, 32'hAABB11DD);
    step();
    idle();
    #1;
    check("byte_store", qa, 32'hAABB11DD);

    // collision merge
    rna = 4;
    we0 = 1; wn0 = 4; d0 = 32'h11111111; be0 = 4'hF;
    we1 = 1; wn1 = 4; d1 = 32'h22222222; be1 = 4'b0101;
    #1;
    check("merge_bypass", qa, 32'h11221122);
    step();
    idle();
    #1;
    check("merge_store", qa, 32'h11221122);

    // full collision: port 1 wins every lane
    rnb = 10;
    we0 = 1; wn0 = 10; d0 = 32'h01020304; be0 = 4'hF;
    we1 = 1; wn1 = 10; d1 = 32'hA0B0C0D0; be1 = 4'hF;
    step();
    idle();
    #1;
    check("prio_store", qb, 32'hA0B0C0D0);

    // zero register
    rna = 0; rnb = 0;
    we0 = 1; wn0 = 0; d0 = 32'hFFFFFFFF; be0 = 4'hF;
    we1 = 1; wn1 = 0; d1 = 32'hFFFFFFFF; be1 = 4'hF;
    pend_set = 1; pend_wn = 0;
    #1;
    check("zero_qa_wr", qa, 32'h0);
    check("zero_qb_wr", qb, 32'h0);
    step();
    idle();
    #1;
    check("zero_qa", qa, 32'h0);
    check("zero_busy_a", {31'b0, busy_a}, 32'h0);

    // scoreboard set and empty-byte-enable writeback
    rna = 9;
    pend_set = 1; pend_wn = 9;
    #1;
    check("sb_no_comb_busy", {31'b0, busy_a}, 32'h0);
    step();
    idle();
    #1;
    check("sb_busy_set", {31'b0, busy_a}, 32'h1);
    we1 = 1; wn1 = 9; d1 = 32'hFFFFFFFF; be1 = 4'h0;
    #1;
    check("sb_busy_bypass_clr", {31'b0, busy_a}, 32'h0);
    check("sb_be0_data_byp", qa, 32'h0);
    step();
    idle();
    #1;
    check("sb_busy_cleared", {31'b0, busy_a}, 32'h0);
    check("sb_be0_data", qa, 32'h0);

    // set/clear race on r6
    rna = 6;
    pend_set = 1; pend_wn = 6;
    step();
    idle();
    #1;
    check("race_pending", {31'b0, busy_a}, 32'h1);
    we0 = 1; wn0 = 6; d0 = 32'hCAFEF00D; be0 = 4'hF;
    pend_set = 1; pend_wn = 6;
    #1;
    check("race_fwd_data", qa, 32'hCAFEF00D);
    step();
    idle();
    #1;
    check("race_busy", {31'b0, busy_a}, 32'h1);
    check("race_data", qa, 32'hCAFEF00D);

    // a single writeback clears a doubly-set entry
    pend_set = 1; pend_wn = 6;
    step();
    idle();
    we1 = 1; wn1 = 6; d1 = 32'h0; be1 = 4'h0;
    step();
    idle();
    #1;
    check("race_single_clear", {31'b0, busy_a}, 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
